// File: rtl/ram_loader_pkg.sv
// Shared loader definitions: protocol FSM encodings, 8N1 frame constants and
// the length-byte decoding helper.
package ram_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEN   = 3'd1,
    ST_DATA  = 3'd2,
    ST_CSUM  = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERROR = 3'd5
  } ld_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  localparam int         DATA_BITS      = 8;
  localparam int         STOP_BITS      = 1;
  localparam logic [8:0] LEN_ZERO_COUNT = 9'd256;

  // A length byte of 0x00 stands for a full 256-byte image.
  function automatic logic [8:0] len_to_count(input logic [7:0] len);
    return (len == 8'd0) ? LEN_ZERO_COUNT : {1'b0, len};
  endfunction

endpackage

// File: rtl/ram_loader_uart_rx.sv
// 8N1 serial receiver: 2-flop synchronizer, mid-bit sampling timer, LSB-first
// shift register. Emits one-cycle frame_start / byte_valid / frame_err pulses.
module uart_rx
  import ram_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err,
  output logic       frame_start
);

  localparam int            CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

  logic          rx_meta, rx_sync;
  rx_state_t     st, st_d;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          cnt_clr, sample, start_ok, stop_ok, stop_bad;

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      st      <= RX_IDLE;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      st      <= st_d;
    end

  always_comb begin
    st_d     = st;
    cnt_clr  = 1'b0;
    sample   = 1'b0;
    start_ok = 1'b0;
    stop_ok  = 1'b0;
    stop_bad = 1'b0;
    case (st)
      RX_IDLE: begin
        cnt_clr = 1'b1;
        if (!rx_sync) st_d = RX_START;
      end
      // Start bit must still be low at its midpoint, otherwise it was a glitch.
      RX_START: if (cnt == HALF) begin
        cnt_clr = 1'b1;
        if (!rx_sync) begin
          st_d     = RX_DATA;
          start_ok = 1'b1;
        end else begin
          st_d = RX_IDLE;
        end
      end
      RX_DATA: if (cnt == FULL) begin
        cnt_clr = 1'b1;
        sample  = 1'b1;
        if (bit_idx == 3'(DATA_BITS - 1)) st_d = RX_STOP;
      end
      RX_STOP: if (cnt == FULL) begin
        cnt_clr  = 1'b1;
        st_d     = RX_IDLE;
        stop_ok  = rx_sync;
        stop_bad = !rx_sync;
      end
      default: st_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      cnt         <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      byte_valid  <= 1'b0;
      frame_err   <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      cnt         <= cnt_clr ? '0 : cnt + 1'b1;
      byte_valid  <= stop_ok;
      frame_err   <= stop_bad;
      frame_start <= start_ok;
      if (start_ok) bit_idx <= '0;
      else if (sample) bit_idx <= bit_idx + 3'd1;
      if (sample) shreg <= {rx_sync, shreg[7:1]};
    end

  assign rx_byte = shreg;

endmodule

// File: rtl/ram_loader.sv
// Serial program loader: length-prefixed image over 8N1 written into RAM from 0x00
// while the CPU is held in reset. LOADER_CHECKSUM_EN adds a trailing sum byte check.
module ram_loader
  import ram_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_data,
  output logic       mem_we,
  output logic       cpu_hold,
  output logic       done,
  output logic       error
);

`ifdef LOADER_CHECKSUM_EN
  localparam ld_state_t AFTER_DATA = ST_CSUM;
`else
  localparam ld_state_t AFTER_DATA = ST_DONE;
`endif

  logic [7:0] rx_byte;
  logic       byte_valid, frame_err, frame_start;
  ld_state_t  state, state_d;
  logic [8:0] remain;
  logic       hold_q;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk         (clk),
    .reset_n     (reset_n),
    .rx          (rx),
    .rx_byte     (rx_byte),
    .byte_valid  (byte_valid),
    .frame_err   (frame_err),
    .frame_start (frame_start)
  );

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] sum;

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n)                          sum <= '0;
    else if (state == ST_LEN && byte_valid) sum <= '0;
    else if (mem_we)                        sum <= sum + mem_data;
`endif

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_d;

  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE:  if (frame_start) state_d = ST_LEN;
      ST_LEN:   if (byte_valid)  state_d = ST_DATA;
      ST_DATA:  if (mem_we && remain == 9'd1) state_d = AFTER_DATA;
`ifdef LOADER_CHECKSUM_EN
      ST_CSUM:  if (byte_valid) state_d = (rx_byte == sum) ? ST_DONE : ST_ERROR;
`endif
      ST_DONE:  state_d = ST_IDLE;
      ST_ERROR: state_d = ST_ERROR;
      default:  state_d = ST_ERROR;
    endcase
    if (frame_err) state_d = ST_ERROR;
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      mem_addr <= '0;
      mem_data <= '0;
      mem_we   <= 1'b0;
      remain   <= '0;
      hold_q   <= 1'b1;
      error    <= 1'b0;
    end else begin
      mem_we <= (state == ST_DATA) && byte_valid;
      if (state == ST_DATA && byte_valid) mem_data <= rx_byte;
      // Address advances the cycle after each strobe, wrapping 0xFF -> 0x00.
      if (state == ST_LEN && byte_valid) begin
        remain   <= len_to_count(rx_byte);
        mem_addr <= '0;
        hold_q   <= 1'b1;
      end else if (mem_we) begin
        mem_addr <= mem_addr + 8'd1;
        remain   <= remain - 9'd1;
      end
      if (state == ST_DONE) hold_q <= 1'b0;
      if (state_d == ST_ERROR) error <= 1'b1;
    end

  assign done     = (state == ST_DONE);
  assign cpu_hold = (hold_q || state == ST_ERROR) && state != ST_DONE;

endmodule

// File: tb/tb_ram_loader.sv
// Directed bench for ram_loader: RAM writes are scoreboarded against expected
// (addr,data) pairs queued as each byte is sent over the serial line.
module tb_ram_loader;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] mem_addr, mem_data;
  logic       mem_we, cpu_hold, done, error;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int we_cnt = 0;
  int hold_bad = 0;
  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];
  logic [7:0]  pay[$];

  always #5 clk = ~clk;

  ram_loader #(.CLKS_PER_BIT(CPB)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .rx       (rx),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .mem_we   (mem_we),
    .cpu_hold (cpu_hold),
    .done     (done),
    .error    (error)
  );

  // Capture writes and done pulses; cpu_hold must be high on writes, low on done.
  always @(negedge clk) if (reset_n) begin
    if (mem_we) begin
      got_q.push_back({mem_addr, mem_data});
      we_cnt++;
      if (!cpu_hold) hold_bad++;
    end
    if (done) begin
      done_cnt++;
      if (cpu_hold) hold_bad++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(CPB);
    end
    rx = stop;
    tick(CPB);
    rx = 1'b1;
  endtask

  task automatic load(input logic [7:0] len, input int n);
    logic [7:0] s;
    s = 8'd0;
    send_byte(len, 1'b1);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({8'(i), pay[i]});
      s = s + pay[i];
      send_byte(pay[i], 1'b1);
    end
`ifdef LOADER_CHECKSUM_EN
    send_byte(s, 1'b1);
`endif
  endtask

  task automatic drain(input string tag);
    chk({tag, " count"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0)
      chk({tag, " wr"}, got_q.pop_front(), exp_q.pop_front());
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic check_reset(input string tag);
    chk({tag, " addr"}, mem_addr, 8'h00);
    chk({tag, " data"}, mem_data, 8'h00);
    chk({tag, " we"},   mem_we,   1'b0);
    chk({tag, " hold"}, cpu_hold, 1'b1);
    chk({tag, " done"}, done,     1'b0);
    chk({tag, " err"},  error,    1'b0);
  endtask

  initial begin
    reset_n = 1'b0;
    tick(3);
    check_reset("rst");
    reset_n = 1'b1;
    tick(2);

    // Three-byte image
    pay = '{8'hA1, 8'hB2, 8'hC3};
    load(8'h03, 3);
    tick(12);
    drain("t1");
    chk("t1 done", done_cnt, 1);
    chk("t1 hold", cpu_hold, 1'b0);
    chk("t1 err", error, 1'b0);
    chk("t1 holdseq", hold_bad, 0);

    // Full 256-byte image, address wraps with no extra write
    pay.delete();
    for (int i = 0; i < 256; i++) pay.push_back(8'(i));
    load(8'h00, 256);
    tick(12);
    drain("t2");
    chk("t2 done", done_cnt, 2);
    chk("t2 wecnt", we_cnt, 259);
    chk("t2 addr", mem_addr, 8'h00);
    chk("t2 hold", cpu_hold, 1'b0);
    chk("t2 holdseq", hold_bad, 0);

    // One-clock glitch while idle must not start a frame
    rx = 1'b0;
    tick(1);
    rx = 1'b1;
    tick(60);
    chk("glitch wecnt", we_cnt, 259);
    chk("glitch done", done_cnt, 2);
    chk("glitch hold", cpu_hold, 1'b0);
    chk("glitch err", error, 1'b0);

    // Reset mid-image, then a fresh one-byte load
    send_byte(8'h04, 1'b1);
    exp_q.push_back(16'h0011);
    send_byte(8'h11, 1'b1);
    exp_q.push_back(16'h0122);
    send_byte(8'h22, 1'b1);
    tick(4);
    reset_n = 1'b0;
    tick(1);
    check_reset("t3 rst");
    reset_n = 1'b1;
    tick(2);
    drain("t3a");
    pay = '{8'h55};
    load(8'h01, 1);
    tick(12);
    drain("t3b");
    chk("t3 done", done_cnt, 3);
    chk("t3 hold", cpu_hold, 1'b0);
    chk("t3 err", error, 1'b0);

    // Framing error on second payload byte: sticky error, later bytes ignored
    send_byte(8'h03, 1'b1);
    exp_q.push_back(16'h0066);
    send_byte(8'h66, 1'b1);
    send_byte(8'h77, 1'b0);
    send_byte(8'h88, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h99, 1'b1);
    tick(12);
    drain("t4");
    chk("t4 err", error, 1'b1);
    chk("t4 hold", cpu_hold, 1'b1);
    chk("t4 done", done_cnt, 3);

`ifdef LOADER_CHECKSUM_EN
    reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1;
    tick(2);
    pay = '{8'h10, 8'h20};
    load(8'h02, 2);
    tick(12);
    drain("cs ok");
    chk("cs ok done", done_cnt, 4);
    chk("cs ok err", error, 1'b0);
    chk("cs ok hold", cpu_hold, 1'b0);

    send_byte(8'h02, 1'b1);
    exp_q.push_back(16'h0010);
    send_byte(8'h10, 1'b1);
    exp_q.push_back(16'h0120);
    send_byte(8'h20, 1'b1);
    send_byte(8'h31, 1'b1);
    tick(12);
    drain("cs bad");
    chk("cs bad err", error, 1'b1);
    chk("cs bad hold", cpu_hold, 1'b1);
    chk("cs bad done", done_cnt, 4);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
